mem_arbiter: RTL

Arbiter between the instruction-fetch path and the memory/writeback stage for a single shared backing-memory port. It accepts one request at a time from either requester and holds it on the memory port until accepted. For reads it steers the returning data to the requester that issued it. It sits between the icache/dcache miss logic and the main memory interface, and allows one transaction in flight.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IC) and data (DC) requesters,
// one transaction in flight. Define MEM_ARB_RR_EN for round-robin instead of fixed DC priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_resp_valid,
    output logic [DATA_WIDTH-1:0] ic_resp_data,
    input  logic                  dc_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic                  dc_req_rw,
    input  logic [DATA_WIDTH-1:0] dc_req_wdata,
    input  logic [3:0]            dc_req_wmask,
    output logic                  dc_req_ready,
    output logic                  dc_resp_valid,
    output logic [DATA_WIDTH-1:0] dc_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_rw,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic [1:0]            dbg_state
);

    // Handshake: a request transfers on a cycle where valid and ready are both high;
    // the requester holds its payload stable while valid is high and ready is low.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    state_t                state, state_nxt;
    logic                  owner;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_rw;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [3:0]            lat_wmask;
    logic                  dc_wins;
    logic                  grant_dc;
    logic                  grant_ic;

`ifdef MEM_ARB_RR_EN
    logic last_owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= OWN_IC;
        end else if (grant_dc || grant_ic) begin
            last_owner <= grant_dc;
        end
    end

    // On contention the side that did not win last time gets the grant.
    always_comb dc_wins = dc_req_valid && (!ic_req_valid || (last_owner == OWN_IC));
`else
    always_comb dc_wins = dc_req_valid;
`endif

    always_comb begin
        grant_dc = (state == ST_IDLE) && dc_wins;
        grant_ic = (state == ST_IDLE) && ic_req_valid && !dc_wins;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        ic_resp_valid = 1'b0;
        dc_resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                ic_req_ready = grant_ic;
                dc_req_ready = grant_dc;
                if (grant_dc || grant_ic) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = lat_rw ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                ic_resp_valid = (owner == OWN_IC) && mem_resp_valid;
                dc_resp_valid = (owner == OWN_DC) && mem_resp_valid;
                if (mem_resp_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Instruction fetches are always reads, so their write fields latch as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner     <= OWN_IC;
            lat_addr  <= '0;
            lat_rw    <= 1'b0;
            lat_wdata <= '0;
            lat_wmask <= 4'b0000;
        end else if (grant_dc) begin
            owner     <= OWN_DC;
            lat_addr  <= dc_req_addr;
            lat_rw    <= dc_req_rw;
            lat_wdata <= dc_req_wdata;
            lat_wmask <= dc_req_wmask;
        end else if (grant_ic) begin
            owner     <= OWN_IC;
            lat_addr  <= ic_req_addr;
            lat_rw    <= 1'b0;
            lat_wdata <= '0;
            lat_wmask <= 4'b0000;
        end
    end

    always_comb begin
        mem_req_addr  = lat_addr;
        mem_req_rw    = lat_rw;
        mem_req_wdata = lat_wdata;
        mem_req_wmask = lat_wmask;
        ic_resp_data  = mem_resp_data;
        dc_resp_data  = mem_resp_data;
        dbg_state     = state;
    end

endmodule
